oled_frame_renderer: RTL and testbench
======================================

# oled_frame_renderer

Upstream stage of the SSD1306 SPI display driver. Once per frame it snapshots the game-object positions: ball position in fixed point, plus two paddle rows. It then streams the 1024-byte page-major frame (8 pages × 128 columns, bit n = row 8·page+n) over a valid/ready byte interface. The SPI driver pops one byte per data transfer. The renderer replaces the single-pixel comparison inside the driver with full ball and paddle drawing.

## Interface
- BALL_SIZE, 2: ball side length in pixels (square, top-left anchored), 1..8
- PADDLE_H, 12: paddle height in pixels, 1..64
- PADDLE_L_COL, 2: left paddle column (1 px wide)
- PADDLE_R_COL, 125: right paddle column (1 px wide)
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- ball_x  in  11  ball column fixed point: [10:4] column 0..127, [3:0] fraction (ignored)
- ball_y  in  10  ball row fixed point: [9:4] row 0..63, [3:0] fraction (ignored)
- paddle_l_y  in  6  left paddle top row
- paddle_r_y  in  6  right paddle top row
- out_data  out  8  frame byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts byte this cycle
- out_first  out  1  qualifies byte index 0 of a frame
- out_last  out  1  qualifies byte index 1023 of a frame

## Operation
- States: LATCH, STREAM.
- Reset: state=LATCH, idx=0, out_valid=0, out_data=0, out_first=0, out_last=0, snapshot registers=0.
- LATCH (1 cycle): capture ball_x[10:4], ball_y[9:4], paddle_l_y and paddle_r_y into the snapshot. Load byte 0 into the output register. Next cycle enter STREAM with out_valid=1.
- STREAM: idx 10 bits; page = idx[9:7], col = idx[6:0].
  - Handshake = out_valid & out_ready.
  - Handshake on idx<1023: idx+1, next byte registered into out_data the following cycle, no bubble.
  - Handshake on idx=1023: out_valid=0, go to LATCH.
- No handshake: out_data, out_first and out_last hold stable.
- Byte content for (page, col): bit n set iff row r = 8·page+n is covered by either object:
  - Ball: col in [bx, bx+BALL_SIZE−1] and r in [by, by+BALL_SIZE−1].
  - Paddle: col==PADDLE_x_COL and r in [py, py+PADDLE_H−1].
- Range compares use 8-bit unsigned arithmetic so bx+BALL_SIZE and py+PADDLE_H never wrap. Objects are clipped at column 127 and row 63. Nothing wraps to column 0 or row 0.
- Inputs are sampled only in LATCH. Mid-frame input changes have no effect until the next frame.
- out_first = (idx==0)&out_valid; out_last = (idx==1023)&out_valid.

## Timing
- rst deasserted at cycle 0 (first cycle with rst low): LATCH in cycle 0; out_valid=1 with byte 0 from cycle 1.
- Back-to-back frames: exactly one out_valid=0 cycle (LATCH) between the out_last handshake and the next out_first.
- Sustained throughput with out_ready held high: 1 byte/cycle.
- rst asserted mid-frame: outputs reach their reset values on the next edge. The partial frame is abandoned and streaming restarts at byte 0 with a fresh snapshot.
- out_valid never drops without a handshake, except on rst.

## Structure
- Shared package `pong_pkg` holds:
  - SCREEN_COLS=128, SCREEN_PAGES=8, FRAME_BYTES=1024.
  - Fixed-point field positions: X_INT_MSB=10, X_INT_LSB=4, Y_INT_MSB=9, Y_INT_LSB=4.
  - State encoding.
- Sub-module `column_byte_render`: purely combinational. Takes (page, col, snapshot) and returns the 8-bit byte. The bench can instantiate it alone as a reference model.

## Test plan
- Ball x=11'h400, y=10'h200, paddles at row 0 → byte 576=8'h03, byte 577=8'h03, byte 578=8'h00. Byte 2=8'hFF, byte 130=8'h0F, byte 125=8'hFF, byte 253=8'h0F. All other bytes 0.
- out_ready low for 5 cycles while idx=10 → out_data, out_valid and out_first/out_last unchanged. Byte 11 is presented on the cycle after ready returns high.
- paddle_l_y=60, ball at column 127 row 63 → byte 898=8'hF0, byte 1023=8'h80. Byte 2 and byte 0 carry no wrapped bits, and nothing wraps into byte 896.
- ball_x changed at idx=300 → the rest of the frame uses the old snapshot. The next frame reflects the new position after exactly one LATCH bubble following out_last.
- rst pulsed at idx=700 → out_valid=0 during rst. The first valid byte after rst has out_first=1 and reflects the current inputs.
- out_ready held high for two frames → 1024 consecutive valid cycles, 1 idle cycle, 1024 valid cycles. Exactly one out_first and one out_last per frame.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: screen geometry, fixed-point field positions and renderer state/snapshot types.
package pong_pkg;
  localparam int SCREEN_COLS = 128;
  localparam int SCREEN_PAGES = 8;
  localparam int FRAME_BYTES = 1024;
  localparam int X_INT_MSB = 10;
  localparam int X_INT_LSB = 4;
  localparam int Y_INT_MSB = 9;
  localparam int Y_INT_LSB = 4;
  typedef enum logic {LATCH, STREAM} state_t;
  typedef struct packed {
    logic [6:0] bx;
    logic [5:0] by;
    logic [5:0] pl;
    logic [5:0] pr;
  } snap_t;
  // 8-bit bounds keep lo+len from wrapping for every legal position
  function automatic logic in_span(logic [7:0] v, logic [7:0] lo, logic [7:0] len);
    return v >= lo && v < lo + len;
  endfunction
endpackage

// File: rtl/column_byte_render.sv
// column_byte_render: combinational 8-row pixel byte for one (page, col) of the ball/paddle scene.
module column_byte_render import pong_pkg::*; #(
  parameter int BALL_SIZE = 2,
  parameter int PADDLE_H = 12,
  parameter int PADDLE_L_COL = 2,
  parameter int PADDLE_R_COL = 125
) (
  input  logic [2:0] page,
  input  logic [6:0] col,
  input  snap_t      snap,
  output logic [7:0] data
);
  localparam logic [7:0] BS = 8'(BALL_SIZE);
  localparam logic [7:0] PH = 8'(PADDLE_H);
  logic [7:0] c;
  logic ball_col, l_col, r_col;
  assign c = {1'b0, col};
  assign ball_col = in_span(c, {1'b0, snap.bx}, BS);
  assign l_col = c == 8'(PADDLE_L_COL);
  assign r_col = c == 8'(PADDLE_R_COL);
  for (genvar i = 0; i < 8; i++) begin : g_bit
    logic [7:0] r;
    assign r = {2'b0, page, 3'(i)};
    assign data[i] = (ball_col && in_span(r, {2'b0, snap.by}, BS)) ||
                     (l_col && in_span(r, {2'b0, snap.pl}, PH)) ||
                     (r_col && in_span(r, {2'b0, snap.pr}, PH));
  end
endmodule

// File: rtl/oled_frame_renderer.sv
// oled_frame_renderer: snapshots object positions per frame and streams the page-major frame bytes.
module oled_frame_renderer import pong_pkg::*; #(
  parameter int BALL_SIZE = 2,
  parameter int PADDLE_H = 12,
  parameter int PADDLE_L_COL = 2,
  parameter int PADDLE_R_COL = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] ball_x,
  input  logic [9:0]  ball_y,
  input  logic [5:0]  paddle_l_y,
  input  logic [5:0]  paddle_r_y,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last
);
  localparam int COL_W = $clog2(SCREEN_COLS);
  localparam int PAGE_W = $clog2(SCREEN_PAGES);
  localparam logic [9:0] LAST = 10'(FRAME_BYTES - 1);
  state_t state;
  logic [9:0] idx, nidx;
  snap_t snap, live, src;
  logic [7:0] next_byte;
  logic hs;
  logic unused_frac;
  assign unused_frac = ^{ball_x[X_INT_LSB-1:0], ball_y[Y_INT_LSB-1:0]};
  assign live = {ball_x[X_INT_MSB:X_INT_LSB], ball_y[Y_INT_MSB:Y_INT_LSB], paddle_l_y, paddle_r_y};
  // in LATCH byte 0 is rendered from the live inputs being captured this cycle
  assign src = state == LATCH ? live : snap;
  assign nidx = state == LATCH ? '0 : idx + 10'd1;
  assign hs = out_valid & out_ready;
  column_byte_render #(
    .BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H),
    .PADDLE_L_COL(PADDLE_L_COL), .PADDLE_R_COL(PADDLE_R_COL)
  ) u_render (
    .page(nidx[COL_W+PAGE_W-1:COL_W]),
    .col(nidx[COL_W-1:0]),
    .snap(src),
    .data(next_byte)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LATCH;
      idx <= '0;
      snap <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last <= 1'b0;
    end else if (state == LATCH) begin
      state <= STREAM;
      snap <= live;
      idx <= '0;
      out_data <= next_byte;
      out_valid <= 1'b1;
      out_first <= 1'b1;
      out_last <= 1'b0;
    end else if (hs && idx == LAST) begin
      state <= LATCH;
      idx <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last <= 1'b0;
    end else if (hs) begin
      idx <= nidx;
      out_data <= next_byte;
      out_first <= 1'b0;
      out_last <= nidx == LAST;
    end
  end
endmodule

// File: tb/tb_oled_frame_renderer.sv
// tb_oled_frame_renderer: randomized frame streaming checked against a pixel-level scene model.
module tb_oled_frame_renderer;
  logic clk = 0, rst = 1;
  logic [10:0] ball_x = 0;
  logic [9:0] ball_y = 0;
  logic [5:0] paddle_l_y = 0, paddle_r_y = 0;
  logic [7:0] out_data;
  logic out_valid, out_ready = 1, out_first, out_last;
  int checks = 0, errors = 0;
  logic [7:0] frame_buf [1024];

  oled_frame_renderer dut (
    .clk(clk), .rst(rst), .ball_x(ball_x), .ball_y(ball_y),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit lit(int col, int row, int bx, int by, int pl, int pr);
    return (col >= bx && col < bx + 2 && row >= by && row < by + 2) ||
           (col == 2 && row >= pl && row < pl + 12) ||
           (col == 125 && row >= pr && row < pr + 12);
  endfunction

  function automatic logic [7:0] model(int idx, int bx, int by, int pl, int pr);
    logic [7:0] b = 0;
    for (int n = 0; n < 8; n++) b[n] = lit(idx % 128, (idx / 128) * 8 + n, bx, by, pl, pr);
    return b;
  endfunction

  // Streams one frame from its first byte; returns right after the out_last handshake.
  task automatic stream_frame(input int bx, by, pl, pr, input int ready_pct,
                              input int stall_at, input int change_at, input int abort_at);
    int i = 0, cyc = 0, stalls = 0;
    logic hs;
    while (i < 1024 && i != abort_at && cyc < 8000) begin
      out_ready = ($urandom_range(99) < 32'(ready_pct));
      if (i == stall_at && stalls < 5) begin
        out_ready = 0;
        stalls++;
      end
      if (i == change_at) ball_x = $urandom;
      check("valid", 32'(out_valid), 1);
      check("data", 32'(out_data), 32'(model(i, bx, by, pl, pr)));
      check("first", 32'(out_first), 32'(i == 0));
      check("last", 32'(out_last), 32'(i == 1023));
      frame_buf[i] = out_data;
      hs = out_valid & out_ready;
      step();
      if (hs) i++;
      cyc++;
    end
    if (cyc >= 8000) check("timeout", 0, 1);
    out_ready = 1;
  endtask

  task automatic bubble_then_first();
    check("bubble", 32'(out_valid), 0);
    step();
    check("restart_valid", 32'(out_valid), 1);
    check("restart_first", 32'(out_first), 1);
  endtask

  task automatic randomize_inputs();
    ball_x = $urandom;
    ball_y = $urandom;
    paddle_l_y = $urandom;
    paddle_r_y = $urandom;
  endtask

  initial begin
    ball_x = 11'h400;
    ball_y = 10'h200;
    repeat (3) step();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_first", 32'(out_first), 0);
    check("rst_last", 32'(out_last), 0);
    rst = 0;
    step();
    stream_frame(64, 32, 0, 0, 100, 10, -1, -1);
    check("b576", 32'(frame_buf[576]), 32'h03);
    check("b577", 32'(frame_buf[577]), 32'h03);
    check("b578", 32'(frame_buf[578]), 32'h00);
    check("b2", 32'(frame_buf[2]), 32'hFF);
    check("b130", 32'(frame_buf[130]), 32'h0F);
    check("b125", 32'(frame_buf[125]), 32'hFF);
    check("b253", 32'(frame_buf[253]), 32'h0F);
    ball_x = {7'd127, 4'd9};
    ball_y = {6'd63, 4'd3};
    paddle_l_y = 60;
    paddle_r_y = 20;
    bubble_then_first();
    stream_frame(127, 63, 60, 20, 100, -1, 300, -1);
    check("c898", 32'(frame_buf[898]), 32'hF0);
    check("c1023", 32'(frame_buf[1023]), 32'h80);
    check("c2", 32'(frame_buf[2]), 32'h00);
    check("c0", 32'(frame_buf[0]), 32'h00);
    check("c896", 32'(frame_buf[896]), 32'h00);
    bubble_then_first();
    stream_frame(int'(ball_x[10:4]), 63, 60, 20, 100, -1, -1, -1);
    for (int f = 0; f < 3; f++) begin
      randomize_inputs();
      bubble_then_first();
      stream_frame(int'(ball_x[10:4]), int'(ball_y[9:4]), int'(paddle_l_y), int'(paddle_r_y),
                   f == 2 ? 100 : 60, -1, -1, -1);
    end
    randomize_inputs();
    bubble_then_first();
    stream_frame(int'(ball_x[10:4]), int'(ball_y[9:4]), int'(paddle_l_y), int'(paddle_r_y),
                 100, -1, -1, 700);
    randomize_inputs();
    rst = 1;
    step();
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_first", 32'(out_first), 0);
    check("mid_rst_last", 32'(out_last), 0);
    check("mid_rst_data", 32'(out_data), 0);
    rst = 0;
    step();
    stream_frame(int'(ball_x[10:4]), int'(ball_y[9:4]), int'(paddle_l_y), int'(paddle_r_y),
                 80, -1, -1, -1);
    check("end_bubble", 32'(out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
